// File: rtl/bcd_serial_adder_if.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_serial_adder_if
//  Description : Handshake and operand/result bundle for bcd_serial_adder.
//                The err signal exists only when BCD_CHECK_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bcd_serial_adder_if #(
    parameter int DIGITS = 4
);
    logic                  start;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  cin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   sum;
    logic                  cout;
`ifdef BCD_CHECK_EN
    logic                  err;
`endif

    // Requester side: issues operands, observes status and result
    modport master (
        output start, a, b, cin,
`ifdef BCD_CHECK_EN
        input  err,
`endif
        input  busy, done, sum, cout
    );

    // Adder side
    modport slave (
        input  start, a, b, cin,
`ifdef BCD_CHECK_EN
        output err,
`endif
        output busy, done, sum, cout
    );
endinterface
`default_nettype wire

// File: rtl/bcd_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_serial_adder
//  Description : Multi-digit packed-BCD adder, one decimal digit per clock,
//                least significant digit first. start/busy/done handshake.
//                Optional macro BCD_CHECK_EN adds a sticky non-BCD input flag
//                (err) evaluated on the operands latched at start.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_serial_adder #(
    parameter int DIGITS = 4
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    bcd_serial_adder_if.slave  bus
);
    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic             r_carry;
    logic [IDX_W-1:0] r_idx;
    logic [W-1:0]     r_sum;
    logic             r_cout;

    logic [3:0]       w_da;
    logic [3:0]       w_db;
    logic [4:0]       w_z;
    logic [3:0]       w_digit;
    logic             w_carry;
    logic             w_last;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state: start only matters in IDLE, DONE always returns to IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last)    w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Status outputs are decoded straight from the state register
    always_comb begin
        bus.busy = (r_state == S_RUN);
        bus.done = (r_state == S_DONE);
        bus.sum  = r_sum;
        bus.cout = r_cout;
    end

    // Per-digit decimal add: binary add then +6 correction above nine
    always_comb begin
        w_da    = r_a[{r_idx, 2'b00} +: 4];
        w_db    = r_b[{r_idx, 2'b00} +: 4];
        w_z     = {1'b0, w_da} + {1'b0, w_db} + {4'b0000, r_carry};
        w_carry = (w_z > 5'd9);
        w_digit = w_carry ? (w_z[3:0] + 4'd6) : w_z[3:0];
        w_last  = (r_idx == IDX_W'(DIGITS - 1));
    end

    // Operand capture and digit-serial accumulation of the result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_carry <= bus.cin;
                        r_idx   <= '0;
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_sum[{r_idx, 2'b00} +: 4] <= w_digit;
                    r_carry                    <= w_carry;
                    if (w_last) r_cout <= w_carry;
                    else        r_idx  <= r_idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef BCD_CHECK_EN
    logic w_nonbcd;
    logic r_err;

    // Any operand digit above nine at the moment of acceptance
    always_comb begin
        w_nonbcd = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if ((bus.a[4*i +: 4] > 4'd9) || (bus.b[4*i +: 4] > 4'd9))
                w_nonbcd = 1'b1;
        end
    end

    // Sticky flag, refreshed only when a new operation is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                r_err <= 1'b0;
        else if ((r_state == S_IDLE) && bus.start) r_err <= w_nonbcd;
    end

    assign bus.err = r_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bcd_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_serial_adder
//  Description : Self-checking bench for bcd_serial_adder (DIGITS = 4).
//                Directed table, handshake corner sequences and random ops
//                against a decimal reference model. BCD_CHECK_EN aware.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_serial_adder;
    localparam int DIGITS = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    bcd_serial_adder_if #(.DIGITS(DIGITS)) bus();

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time guard
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] s;
        logic        co;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic is_bcd(input logic [15:0] v);
        for (int i = 0; i < 4; i++)
            if (v[4*i +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int bcd2int(input logic [15:0] v);
        int r = 0;
        for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    // Reference: decimal arithmetic for valid BCD, digit rule otherwise
    task automatic model(input logic [15:0] av, input logic [15:0] bv, input logic c,
                         output logic [15:0] s, output logic co);
        if (is_bcd(av) && is_bcd(bv)) begin
            int n = bcd2int(av) + bcd2int(bv) + int'(c);
            for (int i = 0; i < 4; i++) begin
                s[4*i +: 4] = 4'(n % 10);
                n = n / 10;
            end
            co = (n != 0);
        end else begin
            int carry = int'(c);
            for (int i = 0; i < 4; i++) begin
                int z = int'(av[4*i +: 4]) + int'(bv[4*i +: 4]) + carry;
                if (z > 9) begin s[4*i +: 4] = 4'(z + 6); carry = 1; end
                else       begin s[4*i +: 4] = 4'(z);     carry = 0; end
            end
            co = carry[0];
        end
    endtask

    // One complete operation; checks latency, busy, done drop and result hold
    task automatic do_op(input logic [15:0] av, input logic [15:0] bv, input logic c,
                         output logic [15:0] s, output logic co);
        int lat;
        int busy_bad;
        @(negedge clk);
        bus.start = 1'b1; bus.a = av; bus.b = bv; bus.cin = c;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a = 16'($urandom); bus.b = 16'($urandom); bus.cin = 1'($urandom);
        lat = 0; busy_bad = 0;
        while (bus.done !== 1'b1 && lat < 20) begin
            if (bus.busy !== 1'b1) busy_bad++;
            @(posedge clk); #1;
            lat++;
        end
        if (bus.busy !== 1'b0) busy_bad++;
        check("latency", lat, DIGITS);
        check("busy_window", busy_bad, 0);
        s  = bus.sum;
        co = bus.cout;
        @(posedge clk); #1;
        check("done_pulse_drop", bus.done, 1'b0);
        check("sum_hold", bus.sum, s);
    endtask

    vec_t        vecs[7];
    logic [15:0] s, es, held;
    logic        co, eco;
    logic [15:0] ra, rb;
    logic        rc;
    int          k;
    int          bad;
    logic        seen_done;

    initial begin
        checks = 0; errors = 0;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        rst_n = 1'b0;

        vecs[0] = '{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0};
        vecs[1] = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[2] = '{16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1};
        vecs[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[4] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'h5555, 1'b1};
        vecs[6] = '{16'h0500, 16'h0500, 1'b0, 16'h1000, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_sum",  bus.sum,  16'h0000);
        check("rst_cout", bus.cout, 1'b0);
`ifdef BCD_CHECK_EN
        check("rst_err",  bus.err,  1'b0);
`endif
        @(negedge clk); rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 7; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin, s, co);
            check($sformatf("vec%0d_sum", i),  s,  vecs[i].s);
            check($sformatf("vec%0d_cout", i), co, vecs[i].co);
        end

        // start pulsed in RUN and in DONE is ignored
        @(negedge clk);
        bus.start = 1'b1; bus.a = 16'h1234; bus.b = 16'h5678; bus.cin = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 16'h1111; bus.b = 16'h1111; bus.cin = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        k = 0;
        while (bus.done !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
        check("ign_run_done_seen", bus.done, 1'b1);
        check("ign_run_sum", bus.sum, 16'h6912);
        @(negedge clk); bus.start = 1'b1;
        @(posedge clk); #1; bus.start = 1'b0;
        @(posedge clk); #1;
        check("ign_done_busy", bus.busy, 1'b0);
        check("ign_done_sum",  bus.sum,  16'h6912);
        check("ign_done_cout", bus.cout, 1'b0);

        // Asynchronous reset in the middle of an operation
        @(negedge clk);
        bus.start = 1'b1; bus.a = 16'h9999; bus.b = 16'h0001; bus.cin = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", bus.busy, 1'b0);
        check("abort_done", bus.done, 1'b0);
        check("abort_sum",  bus.sum,  16'h0000);
        check("abort_cout", bus.cout, 1'b0);
        bad = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) bad++;
        end
        check("abort_quiet", bad, 0);
        @(negedge clk); rst_n = 1'b1;
        do_op(16'h0005, 16'h0005, 1'b0, s, co);
        check("post_abort_sum",  s,  16'h0010);
        check("post_abort_cout", co, 1'b0);

        // start held high: second accept DIGITS+2 edges after the first
        @(negedge clk);
        bus.start = 1'b1; bus.a = 16'h1111; bus.b = 16'h2222; bus.cin = 1'b0;
        @(posedge clk); #1;
        bus.a = 16'h4444; bus.b = 16'h0505; bus.cin = 1'b1;
        k = 0; seen_done = 1'b0; held = '0;
        while (k < 20) begin
            @(posedge clk); #1;
            k++;
            if (bus.done === 1'b1) begin seen_done = 1'b1; held = bus.sum; end
            if (seen_done && bus.busy === 1'b1) break;
            if (seen_done && bus.done !== 1'b1) check("hold_idle_sum", bus.sum, 16'h3333);
        end
        bus.start = 1'b0;
        check("b2b_sum1", held, 16'h3333);
        check("b2b_spacing", k, DIGITS + 2);
        k = 0;
        while (bus.done !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
        check("b2b_sum2",  bus.sum,  16'h4950);
        check("b2b_cout2", bus.cout, 1'b0);
        @(posedge clk); #1;

`ifdef BCD_CHECK_EN
        do_op(16'h12A4, 16'h0001, 1'b0, s, co);
        check("err_set_sum", s, 16'h1305);
        check("err_set", bus.err, 1'b1);
        do_op(16'h0001, 16'h0001, 1'b0, s, co);
        check("err_clr_sum", s, 16'h0002);
        check("err_clr", bus.err, 1'b0);
`endif

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) begin
                for (int d = 0; d < 4; d++) begin
                    ra[4*d +: 4] = 4'($urandom_range(0, 9));
                    rb[4*d +: 4] = 4'($urandom_range(0, 9));
                end
            end else begin
                ra = 16'($urandom);
                rb = 16'($urandom);
            end
            rc = 1'($urandom);
            model(ra, rb, rc, es, eco);
            do_op(ra, rb, rc, s, co);
            check($sformatf("rnd%0d_sum", i),  s,  es);
            check($sformatf("rnd%0d_cout", i), co, eco);
`ifdef BCD_CHECK_EN
            check($sformatf("rnd%0d_err", i), bus.err, !(is_bcd(ra) && is_bcd(rb)));
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
